// File: rtl/he_lb_tx_arb_pkg.sv
// Shared types and the round-robin pick function for the he_lb TX arbiter.
// Requester vectors are padded to MAX_REQ so one function serves every build.
package he_lb_tx_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping at n; indices >= n never win.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0] ptr, input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/he_lb_axis_reg.sv
// One-entry AXI-Stream register stage; output is fully registered, so the
// only path from out_ready_i is to in_ready_o.
module he_lb_axis_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/he_lb_tx_arb.sv
// Packet-atomic round-robin arbiter onto one registered AXI-S TX channel.
// IDLE: pick winner from rr_ptr | LOCKED: forward lock_id beats until tlast.
module he_lb_tx_arb
  import he_lb_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 512,
  parameter int USER_W  = 10,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = $clog2(NUM_REQ),
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_tvalid,
  output logic [NUM_REQ-1:0]        req_tready,
  input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
  input  logic [NUM_REQ*KEEP_W-1:0] req_tkeep,
  input  logic [NUM_REQ*USER_W-1:0] req_tuser,
  input  logic [NUM_REQ-1:0]        req_tlast,
  output logic                      tx_tvalid,
  input  logic                      tx_tready,
  output logic [DATA_W-1:0]         tx_tdata,
  output logic [KEEP_W-1:0]         tx_tkeep,
  output logic [USER_W-1:0]         tx_tuser,
  output logic                      tx_tlast,
  output logic [IDX_W-1:0]          grant_id,
  output logic [NUM_REQ*CNT_W-1:0]  pkt_cnt
);

  localparam int PAY_W = 1 + USER_W + KEEP_W + DATA_W;

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     lock_id_q, lock_id_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q [NUM_REQ];

  logic [MAX_REQ-1:0]   vld_pad;
  rr_pick_t             pick;
  logic                 out_free;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 pkt_done;
  logic [PAY_W-1:0]     sel_pay;
  logic [PAY_W-1:0]     out_pay;

  always_comb begin
    vld_pad                = '0;
    vld_pad[NUM_REQ-1:0]   = req_tvalid;
    pick                   = rr_pick(vld_pad, 3'(rr_ptr_q), NUM_REQ);
  end

  assign sel_valid = (state_q == LOCKED) && req_tvalid[lock_id_q];
  assign sel_last  = req_tlast[lock_id_q];
  assign sel_pay   = {sel_last,
                      req_tuser[lock_id_q*USER_W +: USER_W],
                      req_tkeep[lock_id_q*KEEP_W +: KEEP_W],
                      req_tdata[lock_id_q*DATA_W +: DATA_W]};
  assign pkt_done  = sel_valid && out_free && sel_last;

  // Only the lock owner sees ready, so a packet can never be interleaved.
  always_comb begin
    req_tready = '0;
    if (state_q == LOCKED) req_tready[lock_id_q] = out_free;
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d   = LOCKED;
          lock_id_d = IDX_W'(pick.idx);
        end
      end
      LOCKED: begin
        if (pkt_done) begin
          state_d  = IDLE;
          rr_ptr_d = (lock_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : lock_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pkt_done && lock_id_q == IDX_W'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign grant_id = lock_id_q;

  he_lb_axis_reg #(.W(PAY_W)) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (sel_valid),
    .in_ready_o (out_free),
    .in_data_i  (sel_pay),
    .out_valid_o(tx_tvalid),
    .out_ready_i(tx_tready),
    .out_data_o (out_pay)
  );

  assign {tx_tlast, tx_tuser, tx_tkeep, tx_tdata} = out_pay;

endmodule

// File: tb/tb_he_lb_tx_arb.sv
// Self-checking bench for he_lb_tx_arb: cycle-exact vector table, then
// scoreboarded traffic (rotation, backpressure, valid gaps, reset, counter wrap).
module tb_he_lb_tx_arb;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int UW = 10;
  localparam int CW = 4;
  localparam int KW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_tvalid, req_tready, req_tlast;
  logic [NR*DW-1:0] req_tdata;
  logic [NR*KW-1:0] req_tkeep;
  logic [NR*UW-1:0] req_tuser;
  logic             tx_tvalid, tx_tready, tx_tlast;
  logic [DW-1:0]    tx_tdata;
  logic [KW-1:0]    tx_tkeep;
  logic [UW-1:0]    tx_tuser;
  logic [1:0]       grant_id;
  logic [NR*CW-1:0] pkt_cnt;

  he_lb_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tuser(req_tuser), .req_tlast(req_tlast),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser), .tx_tlast(tx_tlast),
    .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t sb_q[$];
  bit    sb_on = 1'b0;

  function automatic logic [DW-1:0] mk_dat(int i, int p, int b);
    return {8'(i), 8'(p), 8'(b), 8'h5A};
  endfunction
  function automatic logic [UW-1:0] mk_usr(int i, int p, int b);
    return {2'(i), 4'(p), 4'(b)};
  endfunction
  function automatic logic [KW-1:0] mk_keep(logic last);
    return last ? 4'h3 : 4'hF;
  endfunction

  task automatic set_req(input int i, input logic v, input int p, input int b, input int nb);
    logic last;
    last = v && (b == nb - 1);
    req_tvalid[i]           = v;
    req_tlast[i]            = last;
    req_tdata[i*DW +: DW]   = mk_dat(i, p, b);
    req_tuser[i*UW +: UW]   = mk_usr(i, p, b);
    req_tkeep[i*KW +: KW]   = mk_keep(last);
  endtask

  task automatic push_pkt(input int i, input int p, input int nb);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      e.d = mk_dat(i, p, b);
      e.u = mk_usr(i, p, b);
      e.l = (b == nb - 1);
      e.k = mk_keep(e.l);
      sb_q.push_back(e);
    end
  endtask

  // Traffic configuration and the bench's own round-robin pointer model.
  int cfg_np [NR];
  int cfg_nb [NR];
  int cfg_dly[NR];
  int gap_req, gap_beat, gap_len;
  bit rnd_tr;
  int m_ptr = 0;

  task automatic push_rr();
    int rem[NR];
    int pc[NR];
    int left;
    int i;
    left = 0;
    for (int k = 0; k < NR; k++) begin rem[k] = cfg_np[k]; pc[k] = 0; left += rem[k]; end
    while (left > 0) begin
      i = m_ptr;
      while (rem[i] == 0) i = (i + 1) % NR;
      push_pkt(i, pc[i], cfg_nb[i]);
      pc[i]++; rem[i]--; left--;
      m_ptr = (i + 1) % NR;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_tvalid = '0; req_tlast = '0; req_tdata = '0; req_tkeep = '0; req_tuser = '0;
    tx_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic run_traffic(input int budget);
    int  p[NR];
    int  b[NR];
    int  dly[NR];
    bit  hs[NR];
    int  gap;
    int  cyc;
    bit  done;
    logic v;
    gap = gap_len;
    cyc = 0;
    for (int i = 0; i < NR; i++) begin p[i] = 0; b[i] = 0; dly[i] = cfg_dly[i]; end
    while (1) begin
      done = 1'b1;
      for (int i = 0; i < NR; i++) if (p[i] < cfg_np[i]) done = 1'b0;
      if (done) break;
      if (cyc >= budget) begin
        n_cmp++; n_bad++;
        $display("FAIL traffic_timeout: got %0d cycles, required completion", cyc);
        break;
      end
      @(negedge clk);
      tx_tready = rnd_tr ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < NR; i++) begin
        v = (p[i] < cfg_np[i]) && (dly[i] == 0);
        if (v && i == gap_req && p[i] == 0 && b[i] == gap_beat && gap > 0) begin
          v = 1'b0;
          gap--;
        end
        set_req(i, v, p[i], b[i], cfg_nb[i]);
      end
      #1;
      chk("rdy_onehot", int'($countones(req_tready) <= 1), 1);
      for (int i = 0; i < NR; i++) hs[i] = req_tvalid[i] && req_tready[i];
      @(posedge clk);
      for (int i = 0; i < NR; i++) begin
        if (dly[i] > 0) dly[i]--;
        else if (hs[i]) begin
          b[i]++;
          if (b[i] == cfg_nb[i]) begin b[i] = 0; p[i]++; end
        end
      end
      cyc++;
    end
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 0, 0, 1);
    tx_tready = 1'b1;
    for (int k = 0; k < 20 && tx_tvalid; k++) @(negedge clk);
    #3;
    chk("drain_tvalid", int'(tx_tvalid), 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  // Scoreboard monitor and AXI-S hold check on the TX side.
  initial begin : mon
    beat_t         e;
    bit            stall;
    logic [DW-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (sb_on) begin
        if (stall) begin
          chk("stall_tvalid", int'(tx_tvalid), 1);
          chk("stall_tdata", int'(tx_tdata), int'(held));
        end
        stall = tx_tvalid && !tx_tready;
        held  = tx_tdata;
        if (tx_tvalid && tx_tready) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected: got beat %0h, required none", tx_tdata);
          end else begin
            e = sb_q.pop_front();
            chk("sb_tdata", int'(tx_tdata), int'(e.d));
            chk("sb_tuser", int'(tx_tuser), int'(e.u));
            chk("sb_tkeep", int'(tx_tkeep), int'(e.k));
            chk("sb_tlast", int'(tx_tlast), int'(e.l));
          end
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  typedef struct {
    logic [2:0]    vld;
    logic [2:0]    last;
    logic [DW-1:0] dat;
    logic          tr;
    logic [2:0]    erdy;
    logic          etv;
    logic [DW-1:0] edat;
    logic          elast;
    logic [1:0]    egid;
    logic [3:0]    ecnt0;
  } vec_t;

  vec_t tbl[18];

  task automatic chk_reset_state(input string tag);
    #1;
    chk({tag, "_tvalid"}, int'(tx_tvalid), 0);
    chk({tag, "_tdata"}, int'(tx_tdata), 0);
    chk({tag, "_tlast"}, int'(tx_tlast), 0);
    chk({tag, "_tready"}, int'(req_tready), 0);
    chk({tag, "_grant"}, int'(grant_id), 0);
    chk({tag, "_pktcnt"}, int'(pkt_cnt), 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    gap_req = -1; gap_beat = 0; gap_len = 0; rnd_tr = 1'b0;
    rst_n = 1'b0;
    tx_tready = 1'b1;
    req_tvalid = '0; req_tlast = '0; req_tdata = '0; req_tkeep = '0; req_tuser = '0;

    // Single req0 3-beat packet, 4-beat packet with tready 1,0,0,1, then req1 single beat.
    tbl[0]  = '{3'b001, 3'b000, 32'h100, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd0, 4'd0};
    tbl[1]  = '{3'b001, 3'b000, 32'h100, 1'b1, 3'b001, 1'b0, 32'h0,         1'b0, 2'd0, 4'd0};
    tbl[2]  = '{3'b001, 3'b000, 32'h101, 1'b1, 3'b001, 1'b1, 32'h100,       1'b0, 2'd0, 4'd0};
    tbl[3]  = '{3'b001, 3'b001, 32'h102, 1'b1, 3'b001, 1'b1, 32'h101,       1'b0, 2'd0, 4'd0};
    tbl[4]  = '{3'b000, 3'b000, 32'h0,   1'b1, 3'b000, 1'b1, 32'h102,       1'b1, 2'd0, 4'd1};
    tbl[5]  = '{3'b000, 3'b000, 32'h0,   1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd0, 4'd1};
    tbl[6]  = '{3'b001, 3'b000, 32'h200, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd0, 4'd1};
    tbl[7]  = '{3'b001, 3'b000, 32'h200, 1'b1, 3'b001, 1'b0, 32'h0,         1'b0, 2'd0, 4'd1};
    tbl[8]  = '{3'b001, 3'b000, 32'h201, 1'b1, 3'b001, 1'b1, 32'h200,       1'b0, 2'd0, 4'd1};
    tbl[9]  = '{3'b001, 3'b000, 32'h202, 1'b0, 3'b000, 1'b1, 32'h201,       1'b0, 2'd0, 4'd1};
    tbl[10] = '{3'b001, 3'b000, 32'h202, 1'b0, 3'b000, 1'b1, 32'h201,       1'b0, 2'd0, 4'd1};
    tbl[11] = '{3'b001, 3'b000, 32'h202, 1'b1, 3'b001, 1'b1, 32'h201,       1'b0, 2'd0, 4'd1};
    tbl[12] = '{3'b001, 3'b001, 32'h203, 1'b1, 3'b001, 1'b1, 32'h202,       1'b0, 2'd0, 4'd1};
    tbl[13] = '{3'b000, 3'b000, 32'h0,   1'b1, 3'b000, 1'b1, 32'h203,       1'b1, 2'd0, 4'd2};
    tbl[14] = '{3'b000, 3'b000, 32'h0,   1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd0, 4'd2};
    tbl[15] = '{3'b010, 3'b010, 32'h300, 1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd0, 4'd2};
    tbl[16] = '{3'b010, 3'b010, 32'h300, 1'b1, 3'b010, 1'b0, 32'h0,         1'b0, 2'd1, 4'd2};
    tbl[17] = '{3'b000, 3'b000, 32'h0,   1'b1, 3'b000, 1'b1, 32'h1000_0300, 1'b1, 2'd1, 4'd2};

    do_reset();
    chk_reset_state("rst0");

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      req_tvalid = tbl[r].vld;
      req_tlast  = tbl[r].last;
      req_tkeep  = '0;
      req_tuser  = '0;
      for (int i = 0; i < NR; i++) req_tdata[i*DW +: DW] = tbl[r].dat | (32'(i) << 28);
      tx_tready  = tbl[r].tr;
      #1;
      chk($sformatf("tbl%0d_rdy", r), int'(req_tready), int'(tbl[r].erdy));
      chk($sformatf("tbl%0d_tvalid", r), int'(tx_tvalid), int'(tbl[r].etv));
      if (tbl[r].etv) begin
        chk($sformatf("tbl%0d_tdata", r), int'(tx_tdata), int'(tbl[r].edat));
        chk($sformatf("tbl%0d_tlast", r), int'(tx_tlast), int'(tbl[r].elast));
      end
      chk($sformatf("tbl%0d_grant", r), int'(grant_id), int'(tbl[r].egid));
      chk($sformatf("tbl%0d_cnt0", r), int'(pkt_cnt[0 +: CW]), int'(tbl[r].ecnt0));
    end
    chk("tbl_cnt1", int'(pkt_cnt[CW +: CW]), 1);

    do_reset();
    chk_reset_state("rst1");
    sb_on = 1'b1;

    // Two requesters continuously valid: strict rotation, 4 packets each.
    cfg_np = '{4, 4, 0}; cfg_nb = '{2, 2, 2}; cfg_dly = '{0, 0, 0};
    push_rr();
    run_traffic(300);
    chk("rr_cnt0", int'(pkt_cnt[0 +: CW]), 4);
    chk("rr_cnt1", int'(pkt_cnt[CW +: CW]), 4);
    chk("rr_cnt2", int'(pkt_cnt[2*CW +: CW]), 0);

    // Three requesters, mixed lengths incl. single-beat, random backpressure.
    do_reset();
    cfg_np = '{3, 3, 3}; cfg_nb = '{1, 2, 3}; cfg_dly = '{0, 0, 0};
    rnd_tr = 1'b1;
    push_rr();
    run_traffic(600);
    rnd_tr = 1'b0;
    chk("bp_cnt0", int'(pkt_cnt[0 +: CW]), 3);
    chk("bp_cnt1", int'(pkt_cnt[CW +: CW]), 3);
    chk("bp_cnt2", int'(pkt_cnt[2*CW +: CW]), 3);

    // Locked req1 drops valid for 5 cycles mid-packet; req0 must wait.
    do_reset();
    cfg_np = '{1, 1, 0}; cfg_nb = '{2, 3, 1}; cfg_dly = '{1, 0, 0};
    gap_req = 1; gap_beat = 1; gap_len = 5;
    push_pkt(1, 0, 3);
    push_pkt(0, 0, 2);
    run_traffic(200);
    gap_req = -1;
    chk("gap_cnt0", int'(pkt_cnt[0 +: CW]), 1);
    chk("gap_cnt1", int'(pkt_cnt[CW +: CW]), 1);

    // Async reset in the middle of a req1 packet.
    sb_on = 1'b0;
    do_reset();
    @(negedge clk);
    set_req(1, 1'b1, 0, 0, 4);
    @(negedge clk);
    @(negedge clk);
    set_req(1, 1'b1, 0, 1, 4);
    #1;
    chk("mid_pre_tvalid", int'(tx_tvalid), 1);
    chk("mid_pre_grant", int'(grant_id), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", int'(tx_tvalid), 0);
    chk("mid_rst_tready", int'(req_tready), 0);
    chk("mid_rst_grant", int'(grant_id), 0);
    set_req(0, 1'b1, 0, 0, 2);
    set_req(1, 1'b1, 0, 0, 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_post_grant", int'(grant_id), 0);
    chk("mid_post_tready", int'(req_tready), 1);
    chk("mid_post_pktcnt", int'(pkt_cnt), 0);

    // Counter wrap on a 4-bit build: 15 packets, then the 16th returns to 0.
    do_reset();
    sb_on = 1'b1;
    cfg_np = '{15, 0, 0}; cfg_nb = '{1, 1, 1}; cfg_dly = '{0, 0, 0};
    push_rr();
    run_traffic(200);
    chk("wrap_cnt15", int'(pkt_cnt[0 +: CW]), 15);
    cfg_np = '{1, 0, 0};
    push_rr();
    run_traffic(50);
    chk("wrap_cnt0", int'(pkt_cnt[0 +: CW]), 0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
